// File: rtl/mem_arbiter.sv
// Purpose : burst-locked round-robin arbiter sharing one table-memory port among NUM_REQ requesters.
// Latency : 1 arbitration cycle from request to mem_ce_o; 1 idle cycle per handover; data/ready pass-through.
// Backpres: losers hold ce and see ready=0; the owner sees mem_ready_i directly; no timeout on a held burst.
// Option  : define MEM_ARB_PRIO0_EN to give requester 0 (control-plane writer) strict priority at arbitration.
module mem_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_ce_i,
   input  logic [NUM_REQ-1:0]             req_we_i,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ-1:0][3:0]        req_width_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [DATA_W-1:0]              req_data_o,
   output logic                           mem_ce_o,
   output logic                           mem_we_o,
   output logic [ADDR_W-1:0]              mem_addr_o,
   output logic [3:0]                     mem_width_o,
   output logic [DATA_W-1:0]              mem_data_o,
   input  logic [DATA_W-1:0]              mem_data_i,
   input  logic                           mem_ready_i,
   output logic [NUM_REQ-1:0]             grant_o,
   output logic                           busy_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      STATE_IDLE = 1'b0,
      STATE_BUSY = 1'b1
   } state_t;

   // One memory command as seen by the table port (ce carried separately).
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        width;
      logic [DATA_W-1:0] data;
   } mem_req_t;

   state_t             state;
   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   rr_ptr;

   logic               win_vld;
   logic [PTR_W-1:0]   win_idx;
   logic               sel_ce;
   logic               active;
   mem_req_t           sel_req;
   mem_req_t           out_req;

   // Index 'off' positions above 'base' on the requester ring (off < NUM_REQ).
   function automatic logic [PTR_W-1:0] ring_idx(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return sum[PTR_W-1:0];
   endfunction

   // Winner search: scan from far to near so the requester closest to rr_ptr overrides the rest.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_ce_i[ring_idx(rr_ptr, k)]) begin
            win_vld = 1'b1;
            win_idx = ring_idx(rr_ptr, k);
         end
      end
`ifdef MEM_ARB_PRIO0_EN
      // Control-plane writer jumps the queue, but only here at arbitration, never mid-burst.
      if (req_ce_i[0]) begin
         win_vld = 1'b1;
         win_idx = '0;
      end
`endif
   end

   // Pass-through mux of the owner's command, forced to zero whenever no burst word is live.
   always_comb begin
      sel_ce        = req_ce_i[grant_idx];
      active        = (state == STATE_BUSY) && sel_ce;
      sel_req.we    = req_we_i[grant_idx];
      sel_req.addr  = req_addr_i[grant_idx];
      sel_req.width = req_width_i[grant_idx];
      sel_req.data  = req_data_i[grant_idx];
      out_req       = active ? sel_req : '0;
   end

   assign mem_ce_o    = active;
   assign mem_we_o    = out_req.we;
   assign mem_addr_o  = out_req.addr;
   assign mem_width_o = out_req.width;
   assign mem_data_o  = out_req.data;

   // Only the live owner sees the memory handshake; ready in idle or on release goes nowhere.
   assign req_ready_o = active ? (grant & {NUM_REQ{mem_ready_i}}) : '0;

   // Read data is a broadcast; requesters qualify it with their own ready.
   assign req_data_o  = mem_data_i;

   assign grant_o     = grant;
   assign busy_o      = (state == STATE_BUSY);

   // Grant FSM: lock on a winner for the whole burst, advance the rotation pointer on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= STATE_IDLE;
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            STATE_IDLE: begin
               if (win_vld) begin
                  state     <= STATE_BUSY;
                  grant_idx <= win_idx;
                  grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
               end
            end
            STATE_BUSY: begin
               if (!sel_ce) begin
                  state  <= STATE_IDLE;
                  grant  <= '0;
                  rr_ptr <= ring_idx(grant_idx, 1);
               end
            end
            default: begin
               state <= STATE_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule
